reorder_buffer: RTL and testbench

- Circular reorder buffer sitting downstream of the reservation station and load/store buffer.
- Allocates an entry per dispatched instruction and captures results broadcast on both CDBs.
- Retires entries in program order, one per cycle, to the register file or to the store path.
- Detects branch/JALR mispredictions at commit and raises the global flush with a redirect PC.

---
 rtl/reorder_buffer_pkg.sv | 39 +++
 rtl/reorder_buffer_commit_check.sv | 21 ++
 rtl/reorder_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: sizing defaults, the id
// convention and the instruction type codes seen at dispatch.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_DEF  = 16;
  localparam int ROB_ID_W_DEF  = 5;
  localparam int NON_DEPENDENT = 0;
  localparam int OPE_WIDTH     = 6;

  typedef logic [ROB_ID_W_DEF-1:0] rob_id_t;

  typedef enum logic [OPE_WIDTH-1:0] {
    OP_NONE = 6'd0,
    ADDI    = 6'd1,
    ADD     = 6'd2,
    LW      = 6'd3,
    JAL     = 6'd4,
    JALR    = 6'd5,
    BEQ     = 6'd6,
    BNE     = 6'd7,
    BLT     = 6'd8,
    BGE     = 6'd9,
    BLTU    = 6'd10,
    BGEU    = 6'd11,
    SB      = 6'd12,
    SH      = 6'd13,
    SW      = 6'd14
  } ope_e;

  function automatic logic is_cond_branch(input logic [OPE_WIDTH-1:0] op);
    return (op == BEQ) || (op == BNE) || (op == BLT) ||
           (op == BGE) || (op == BLTU) || (op == BGEU);
  endfunction

  function automatic logic is_store_op(input logic [OPE_WIDTH-1:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

endpackage

// File: rtl/reorder_buffer_commit_check.sv
// Classifies the head instruction at commit and decides whether it
// redirects fetch (resolved branch disagreeing with prediction, or any JALR).
module reorder_buffer_commit_check
  import reorder_buffer_pkg::*;
(
  input  logic [OPE_WIDTH-1:0] head_type,
  input  logic                 pred_jump,
  input  logic                 act_jump,
  output logic                 is_branch,
  output logic                 is_store,
  output logic                 mispredict_hit
);

  // JAL target is known at fetch, so only JALR and wrong branches flush
  always_comb begin
    is_branch      = is_cond_branch(head_type);
    is_store       = is_store_op(head_type);
    mispredict_hit = (head_type == JALR) || (is_branch && (act_jump != pred_jump));
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order result capture
// from the ALU and load/store CDBs, in-order retirement with flush on
// mispredicted control flow.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEF,
  parameter int ROB_ID_W = ROB_ID_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 enable_from_dsp,
  input  logic [OPE_WIDTH-1:0] type_from_dsp,
  input  logic [4:0]           rd_from_dsp,
  input  logic [31:0]          pc_from_dsp,
  input  logic                 pred_jump_from_dsp,
  output logic [ROB_ID_W-1:0]  rob_id_to_dsp,
  output logic                 full_rob,
  input  logic [ROB_ID_W-1:0]  query_j_id,
  input  logic [ROB_ID_W-1:0]  query_k_id,
  output logic                 ready_j,
  output logic                 ready_k,
  output logic [31:0]          value_j,
  output logic [31:0]          value_k,
  input  logic                 enable_cdb_rs,
  input  logic [ROB_ID_W-1:0]  cdb_rs_rob_id,
  input  logic [31:0]          cdb_rs_value,
  input  logic                 cdb_rs_jump,
  input  logic [31:0]          cdb_rs_pc_next,
  input  logic                 enable_cdb_lsb,
  input  logic [ROB_ID_W-1:0]  cdb_lsb_rob_id,
  input  logic [31:0]          cdb_lsb_value,
  output logic                 commit_reg_en,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic [ROB_ID_W-1:0]  commit_rob_id,
  output logic                 commit_store_en,
  output logic                 mispredict,
  output logic [31:0]          pc_redirect,
  output logic                 bp_update_en,
  output logic [31:0]          bp_pc,
  output logic                 bp_taken
);

  localparam int                IDX_W    = $clog2(ROB_SIZE);
  localparam logic [IDX_W-1:0]  IDX_ONE  = 1;
  localparam logic [IDX_W:0]    CNT_ONE  = 1;
  localparam logic [IDX_W:0]    FULL_LVL = (IDX_W+1)'(ROB_SIZE - 1);
  localparam logic [ROB_ID_W-1:0] ID_ONE  = 1;
  localparam logic [ROB_ID_W-1:0] ID_NONE = ROB_ID_W'(NON_DEPENDENT);

  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;

  logic [ROB_SIZE-1:0]  busy, ent_ready, ent_pred, ent_act;
  logic [OPE_WIDTH-1:0] ent_type    [ROB_SIZE];
  logic [4:0]           ent_rd      [ROB_SIZE];
  logic [31:0]          ent_pc      [ROB_SIZE];
  logic [31:0]          ent_value   [ROB_SIZE];
  logic [31:0]          ent_pc_next [ROB_SIZE];

  function automatic logic [IDX_W-1:0] id_to_idx(input logic [ROB_ID_W-1:0] id);
    logic [ROB_ID_W-1:0] t;
    t = id - ID_ONE;
    return t[IDX_W-1:0];
  endfunction

  function automatic logic [ROB_ID_W-1:0] idx_to_id(input logic [IDX_W-1:0] idx);
    return ROB_ID_W'(idx) + ID_ONE;
  endfunction

  // Everything upstream flushes on the same pulse, so inputs seen while
  // mispredict is high belong to the squashed path.
  logic dsp_we, rs_we, lsb_we;
  logic [IDX_W-1:0] rs_idx, lsb_idx;
  assign dsp_we  = enable_from_dsp && !mispredict;
  assign rs_we   = enable_cdb_rs  && (cdb_rs_rob_id  != ID_NONE) && !mispredict;
  assign lsb_we  = enable_cdb_lsb && (cdb_lsb_rob_id != ID_NONE) && !mispredict;
  assign rs_idx  = id_to_idx(cdb_rs_rob_id);
  assign lsb_idx = id_to_idx(cdb_lsb_rob_id);

  assign rob_id_to_dsp = idx_to_id(tail);
  assign full_rob      = (count >= FULL_LVL);

  // ---- stage p0: head inspection for commit ----
  logic head_vld_p0, is_branch_p0, is_store_p0, flush_p0;
  assign head_vld_p0 = busy[head] && ent_ready[head];

  reorder_buffer_commit_check u_commit_check (
    .head_type      (ent_type[head]),
    .pred_jump      (ent_pred[head]),
    .act_jump       (ent_act[head]),
    .is_branch      (is_branch_p0),
    .is_store       (is_store_p0),
    .mispredict_hit (flush_p0)
  );

  function automatic logic [32:0] lookup(input logic [ROB_ID_W-1:0] id);
    logic [IDX_W-1:0] idx;
    idx = id_to_idx(id);
    if (id == ID_NONE)
      return {1'b1, 32'h0};
    else if (rs_we && (cdb_rs_rob_id == id))
      return {1'b1, cdb_rs_value};
    else if (lsb_we && (cdb_lsb_rob_id == id))
      return {1'b1, cdb_lsb_value};
    else
      return {busy[idx] && ent_ready[idx], ent_value[idx]};
  endfunction

  // Operand lookup with same-cycle CDB forwarding, ALU bus first
  always_comb begin
    {ready_j, value_j} = lookup(query_j_id);
    {ready_k, value_k} = lookup(query_k_id);
  end

  // Control state and registered commit outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      busy            <= '0;
      ent_ready       <= '0;
      commit_reg_en   <= 1'b0;
      commit_rd       <= '0;
      commit_value    <= '0;
      commit_rob_id   <= '0;
      commit_store_en <= 1'b0;
      mispredict      <= 1'b0;
      pc_redirect     <= '0;
      bp_update_en    <= 1'b0;
      bp_pc           <= '0;
      bp_taken        <= 1'b0;
    end else if (rdy) begin
      commit_reg_en   <= 1'b0;
      commit_store_en <= 1'b0;
      mispredict      <= 1'b0;
      bp_update_en    <= 1'b0;

      if (dsp_we) begin
        busy[tail]      <= 1'b1;
        ent_ready[tail] <= 1'b0;
        tail            <= tail + IDX_ONE;
      end
      if (lsb_we) ent_ready[lsb_idx] <= 1'b1;
      if (rs_we)  ent_ready[rs_idx]  <= 1'b1;

      case ({dsp_we, head_vld_p0})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // ---- stage p1: retire head ----
      if (head_vld_p0) begin
        commit_rd       <= ent_rd[head];
        commit_value    <= ent_value[head];
        commit_rob_id   <= idx_to_id(head);
        commit_store_en <= is_store_p0;
        commit_reg_en   <= !is_store_p0 && (ent_rd[head] != 5'd0);
        if (is_branch_p0) begin
          bp_update_en <= 1'b1;
          bp_pc        <= ent_pc[head];
          bp_taken     <= ent_act[head];
        end
        if (flush_p0) begin
          mispredict  <= 1'b1;
          pc_redirect <= ent_pc_next[head];
          busy        <= '0;
          head        <= '0;
          tail        <= '0;
          count       <= '0;
        end else begin
          head       <= head + IDX_ONE;
          busy[head] <= 1'b0;
        end
      end
    end
  end

  // Entry payload; validity is tracked by busy/ready, so no reset needed
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (dsp_we) begin
        ent_type[tail] <= type_from_dsp;
        ent_rd[tail]   <= rd_from_dsp;
        ent_pc[tail]   <= pc_from_dsp;
        ent_pred[tail] <= pred_jump_from_dsp;
      end
      if (lsb_we) ent_value[lsb_idx] <= cdb_lsb_value;
      if (rs_we) begin
        ent_value[rs_idx]   <= cdb_rs_value;
        ent_act[rs_idx]     <= cdb_rs_jump;
        ent_pc_next[rs_idx] <= cdb_rs_pc_next;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation ids, forwarding, in-order
// commit, branch flush, store release, fill/wrap, rdy freeze and async reset.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n, rdy;
  logic                 enable_from_dsp;
  logic [OPE_WIDTH-1:0] type_from_dsp;
  logic [4:0]           rd_from_dsp;
  logic [31:0]          pc_from_dsp;
  logic                 pred_jump_from_dsp;
  logic [4:0]           rob_id_to_dsp;
  logic                 full_rob;
  logic [4:0]           query_j_id, query_k_id;
  logic                 ready_j, ready_k;
  logic [31:0]          value_j, value_k;
  logic                 enable_cdb_rs;
  logic [4:0]           cdb_rs_rob_id;
  logic [31:0]          cdb_rs_value;
  logic                 cdb_rs_jump;
  logic [31:0]          cdb_rs_pc_next;
  logic                 enable_cdb_lsb;
  logic [4:0]           cdb_lsb_rob_id;
  logic [31:0]          cdb_lsb_value;
  logic                 commit_reg_en;
  logic [4:0]           commit_rd;
  logic [31:0]          commit_value;
  logic [4:0]           commit_rob_id;
  logic                 commit_store_en;
  logic                 mispredict;
  logic [31:0]          pc_redirect;
  logic                 bp_update_en;
  logic [31:0]          bp_pc;
  logic                 bp_taken;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_SIZE(16), .ROB_ID_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .enable_from_dsp(enable_from_dsp), .type_from_dsp(type_from_dsp),
    .rd_from_dsp(rd_from_dsp), .pc_from_dsp(pc_from_dsp),
    .pred_jump_from_dsp(pred_jump_from_dsp),
    .rob_id_to_dsp(rob_id_to_dsp), .full_rob(full_rob),
    .query_j_id(query_j_id), .query_k_id(query_k_id),
    .ready_j(ready_j), .ready_k(ready_k), .value_j(value_j), .value_k(value_k),
    .enable_cdb_rs(enable_cdb_rs), .cdb_rs_rob_id(cdb_rs_rob_id),
    .cdb_rs_value(cdb_rs_value), .cdb_rs_jump(cdb_rs_jump),
    .cdb_rs_pc_next(cdb_rs_pc_next),
    .enable_cdb_lsb(enable_cdb_lsb), .cdb_lsb_rob_id(cdb_lsb_rob_id),
    .cdb_lsb_value(cdb_lsb_value),
    .commit_reg_en(commit_reg_en), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_rob_id(commit_rob_id),
    .commit_store_en(commit_store_en), .mispredict(mispredict),
    .pc_redirect(pc_redirect), .bp_update_en(bp_update_en),
    .bp_pc(bp_pc), .bp_taken(bp_taken)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    enable_from_dsp = 0; type_from_dsp = OP_NONE; rd_from_dsp = 0;
    pc_from_dsp = 0; pred_jump_from_dsp = 0;
    query_j_id = 0; query_k_id = 0;
    enable_cdb_rs = 0; cdb_rs_rob_id = 0; cdb_rs_value = 0;
    cdb_rs_jump = 0; cdb_rs_pc_next = 0;
    enable_cdb_lsb = 0; cdb_lsb_rob_id = 0; cdb_lsb_value = 0;
  endtask

  task automatic dsp(input ope_e op, input logic [4:0] rd, input logic [31:0] pc, input logic pj);
    enable_from_dsp = 1; type_from_dsp = op; rd_from_dsp = rd;
    pc_from_dsp = pc; pred_jump_from_dsp = pj;
  endtask

  task automatic rs(input logic [4:0] id, input logic [31:0] v, input logic j, input logic [31:0] pcn);
    enable_cdb_rs = 1; cdb_rs_rob_id = id; cdb_rs_value = v;
    cdb_rs_jump = j; cdb_rs_pc_next = pcn;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; rdy = 1;
    clear_inputs();
    #12;
    check("rst_commit_reg_en", commit_reg_en, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_commit_rob_id", commit_rob_id, 0);
    check("rst_id", rob_id_to_dsp, 1);
    check("rst_full", full_rob, 0);
    @(negedge clk);
    rst_n = 1;

    // single ALU op: id 1, forwarded while broadcast, commits next edge
    dsp(ADDI, 5, 32'h100, 0);
    check("t1_id", rob_id_to_dsp, 1);
    tick();
    enable_from_dsp = 0;
    rs(1, 32'h2A, 0, 32'h104);
    query_j_id = 1;
    #1;
    check("t1_fwd_ready", ready_j, 1);
    check("t1_fwd_value", value_j, 32'h2A);
    tick();
    enable_cdb_rs = 0;
    check("t1_no_early_commit", commit_reg_en, 0);
    tick();
    check("t1_commit_en", commit_reg_en, 1);
    check("t1_commit_rd", commit_rd, 5);
    check("t1_commit_value", commit_value, 32'h2A);
    check("t1_commit_id", commit_rob_id, 1);
    rdy = 0;
    tick();
    check("rdy_hold_pulse", commit_reg_en, 1);
    rdy = 1;
    tick();
    check("t1_pulse_drop", commit_reg_en, 0);
    check("t1_next_id", rob_id_to_dsp, 2);

    // three ops completing out of order retire in order
    for (int i = 0; i < 3; i++) begin
      dsp(ADD, 5'(i + 1), 32'h110 + 32'(4 * i), 0);
      tick();
    end
    enable_from_dsp = 0;
    rs(4, 32'h33, 0, 0);
    tick();
    rs(2, 32'h11, 0, 0);
    tick();
    check("t2_wait_head", commit_reg_en, 0);
    rs(3, 32'h22, 0, 0);
    tick();
    enable_cdb_rs = 0;
    check("t2_c1_id", commit_rob_id, 2);
    check("t2_c1_rd", commit_rd, 1);
    check("t2_c1_val", commit_value, 32'h11);
    tick();
    check("t2_c2_id", commit_rob_id, 3);
    check("t2_c2_val", commit_value, 32'h22);
    tick();
    check("t2_c3_id", commit_rob_id, 4);
    check("t2_c3_rd", commit_rd, 3);
    check("t2_c3_en", commit_reg_en, 1);
    tick();
    check("t2_idle", commit_reg_en, 0);

    // mispredicted BEQ flushes and redirects
    dsp(BEQ, 0, 32'h200, 0);
    check("t3_id", rob_id_to_dsp, 5);
    tick();
    enable_from_dsp = 0;
    rs(5, 0, 1, 32'h240);
    tick();
    enable_cdb_rs = 0;
    tick();
    check("t3_mispredict", mispredict, 1);
    check("t3_redirect", pc_redirect, 32'h240);
    check("t3_bp_en", bp_update_en, 1);
    check("t3_bp_taken", bp_taken, 1);
    check("t3_bp_pc", bp_pc, 32'h200);
    check("t3_no_reg", commit_reg_en, 0);
    check("t3_id_reset", rob_id_to_dsp, 1);
    check("t3_full", full_rob, 0);
    dsp(ADDI, 9, 32'h900, 0);
    tick();
    enable_from_dsp = 0;
    check("t3_flush_drop", mispredict, 0);
    check("t3_dsp_ignored", rob_id_to_dsp, 1);

    // store releases to LSB, no register write
    dsp(SW, 0, 32'h300, 0);
    tick();
    enable_from_dsp = 0;
    enable_cdb_lsb = 1; cdb_lsb_rob_id = 1; cdb_lsb_value = 0;
    tick();
    enable_cdb_lsb = 0;
    tick();
    check("t4_store_en", commit_store_en, 1);
    check("t4_store_noreg", commit_reg_en, 0);
    check("t4_store_id", commit_rob_id, 1);

    // fill to 15 entries, ids 2..16 then wrap to 1
    for (int i = 0; i < 15; i++) begin
      if (i == 14) check("t5_id16", rob_id_to_dsp, 16);
      dsp(ADDI, 7, 32'h400 + 32'(4 * i), 0);
      tick();
      if (i == 13) check("t5_not_full_14", full_rob, 0);
    end
    enable_from_dsp = 0;
    check("t5_full_15", full_rob, 1);
    check("t5_wrap_id", rob_id_to_dsp, 1);
    rs(2, 32'h5, 0, 0);
    tick();
    enable_cdb_rs = 0;
    tick();
    check("t5_commit_id", commit_rob_id, 2);
    check("t5_full_drop", full_rob, 0);
    dsp(ADDI, 8, 32'h500, 0);
    tick();
    enable_from_dsp = 0;
    check("t5_after_wrap_id", rob_id_to_dsp, 2);
    check("t5_full_again", full_rob, 1);

    // queries: same-cycle forward, id 0, not-ready, stored, RS priority
    query_j_id = 4; query_k_id = 0;
    rs(4, 32'h77, 0, 0);
    #1;
    check("t6_fwd_ready", ready_j, 1);
    check("t6_fwd_value", value_j, 32'h77);
    check("t6_q0_ready", ready_k, 1);
    check("t6_q0_value", value_k, 0);
    tick();
    enable_cdb_rs = 0;
    query_k_id = 5;
    #1;
    check("t6_notready", ready_k, 0);
    check("t6_stored_ready", ready_j, 1);
    check("t6_stored_value", value_j, 32'h77);
    query_j_id = 6;
    rs(6, 32'hAA, 0, 0);
    enable_cdb_lsb = 1; cdb_lsb_rob_id = 6; cdb_lsb_value = 32'hBB;
    #1;
    check("t6_prio_fwd", value_j, 32'hAA);
    tick();
    enable_cdb_rs = 0; enable_cdb_lsb = 0;
    #1;
    check("t6_prio_stored", value_j, 32'hAA);

    // async reset mid-commit
    rs(3, 32'h33, 0, 0);
    tick();
    enable_cdb_rs = 0;
    tick();
    check("t7_commit_before_rst", commit_rob_id, 3);
    #2;
    rst_n = 0;
    #1;
    check("t7_rst_reg_en", commit_reg_en, 0);
    check("t7_rst_rob_id", commit_rob_id, 0);
    check("t7_rst_value", commit_value, 0);
    check("t7_rst_full", full_rob, 0);
    check("t7_rst_query", ready_j, 0);
    @(negedge clk);
    rst_n = 1;
    dsp(ADDI, 1, 32'h600, 0);
    check("t7_first_id", rob_id_to_dsp, 1);
    tick();
    enable_from_dsp = 0;
    check("t7_second_id", rob_id_to_dsp, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
